// File: rtl/pmp_pkg.sv
// Shared definitions for the multi-cycle PMP scan checker: address-matching
// modes, privilege codes and the scan FSM state type.
package pmp_pkg;
  localparam logic [1:0] PMP_OFF   = 2'd0;
  localparam logic [1:0] PMP_TOR   = 2'd1;
  localparam logic [1:0] PMP_NA4   = 2'd2;
  localparam logic [1:0] PMP_NAPOT = 2'd3;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} pmpstate_t;
endpackage

// File: rtl/pmp_range_match.sv
// Single-entry PMP region decode: builds [base, top) from cfg/adr and reports
// whether the access byte range [lo, hi] overlaps or lies fully inside it.
module pmp_range_match
  import pmp_pkg::*;
#(
  parameter int PA_BITS = 56
) (
  input  logic [PA_BITS:0]   lo,
  input  logic [PA_BITS:0]   hi,
  input  logic [7:0]         cfg,
  input  logic [PA_BITS-3:0] adr,
  input  logic [PA_BITS-3:0] prevAdr,
  output logic               Overlap,
  output logic               Full
);
  // One extra bit so a NAPOT region covering the whole space has a representable top.
  localparam int W = PA_BITS + 2;

  logic [W-1:0]       w_lo, w_hi, w_adr4, w_prev4, w_bmask, w_base, w_top;
  logic [PA_BITS-2:0] w_adr_x, w_nmask;
  logic               w_valid;
  logic               w_unused;

  assign w_unused = ^{cfg[7:5], cfg[2:0]};
  assign w_lo     = {1'b0, lo};
  assign w_hi     = {1'b0, hi};
  assign w_adr4   = {2'b00, adr, 2'b00};
  assign w_prev4  = {2'b00, prevAdr, 2'b00};
  // Trailing ones plus the next zero: low k+1 bits set, in word units.
  assign w_adr_x  = {1'b0, adr};
  assign w_nmask  = w_adr_x ^ (w_adr_x + 1'b1);
  assign w_bmask  = {1'b0, w_nmask, 2'b11};

  always_comb begin
    w_valid = 1'b0;
    w_base  = '0;
    w_top   = '0;
    case (cfg[4:3])
      PMP_TOR: begin
        w_base  = w_prev4;
        w_top   = w_adr4;
        w_valid = w_top > w_base;
      end
      PMP_NA4: begin
        w_base  = w_adr4;
        w_top   = w_adr4 + W'(4);
        w_valid = 1'b1;
      end
      PMP_NAPOT: begin
        w_base  = w_adr4 & ~w_bmask;
        w_top   = w_base + w_bmask + W'(1);
        w_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign Overlap = w_valid & (w_lo < w_top) & (w_hi >= w_base);
  assign Full    = w_valid & (w_lo >= w_base) & (w_hi < w_top);
endmodule

// File: rtl/pmp_scan_checker.sv
// Multi-cycle PMP checker scanning LANES entries per cycle, lowest index wins.
// Define PMP_PARTIAL_CHECK_EN for full byte-range (partial-match) checking.
module pmp_scan_checker
  import pmp_pkg::*;
#(
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16,
  parameter int LANES       = 4,
  localparam int IDX_W      = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1,
  localparam int CFG_W      = (PMP_ENTRIES > 0) ? 8 * PMP_ENTRIES : 8,
  localparam int ADR_W      = (PA_BITS - 2) * ((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [PA_BITS-1:0] PhysicalAddress,
  input  logic [1:0]         Size,
  input  logic [2:0]         AccessRWX,
  input  logic [1:0]         PrivilegeMode,
  input  logic [CFG_W-1:0]   PMPCfgFlat,
  input  logic [ADR_W-1:0]   PMPAdrFlat,
  input  logic               PMPCSRWrite,
  output logic               RespValid,
  input  logic               RespReady,
  output logic               RespFault,
  output logic               RespMatched,
  output logic [IDX_W-1:0]   RespIdx
);
  localparam int AW       = PA_BITS - 2;
  localparam int LW       = PA_BITS + 1;
  localparam int NGRP     = PMP_ENTRIES / LANES;
  localparam int GRP_W    = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int LAST_GRP = (NGRP > 0) ? NGRP - 1 : 0;

  pmpstate_t          r_state, w_next;
  logic [GRP_W-1:0]   r_grp;
  logic [AW-1:0]      r_prev_adr;
  logic [PA_BITS-1:0] r_pa;
  logic [1:0]         r_size;
  logic [2:0]         r_rwx;
  logic [1:0]         r_priv;
  logic               r_fault, r_matched;
  logic [IDX_W-1:0]   r_idx;

  logic [LW-1:0]      w_lo, w_hi;
  logic               w_hit, w_hit_fault, w_last;
  logic [IDX_W-1:0]   w_win_idx;
  logic [AW-1:0]      w_last_adr;

  assign w_lo = {1'b0, r_pa};
`ifdef PMP_PARTIAL_CHECK_EN
  assign w_hi = w_lo + (LW'(1) << r_size) - LW'(1);
`else
  // Legacy base-address-only match; size plays no part.
  logic w_unused_size;
  assign w_unused_size = ^r_size;
  assign w_hi = w_lo;
`endif

  generate
    if (PMP_ENTRIES > 0) begin : g_scan
      logic [LANES-1:0][7:0]    w_cfg;
      logic [LANES-1:0][AW-1:0] w_adr;
      logic [LANES-1:0]         w_ovl, w_full;
      logic [7:0]               w_win_cfg;
      logic                     w_win_full;

      assign w_cfg = PMPCfgFlat[r_grp*(8*LANES) +: 8*LANES];
      assign w_adr = PMPAdrFlat[r_grp*(AW*LANES) +: AW*LANES];

      for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [AW-1:0] w_prev;
        if (l == 0) begin : g_first
          assign w_prev = r_prev_adr;
        end else begin : g_rest
          assign w_prev = w_adr[l-1];
        end
        pmp_range_match #(.PA_BITS(PA_BITS)) u_match (
          .lo(w_lo), .hi(w_hi), .cfg(w_cfg[l]), .adr(w_adr[l]), .prevAdr(w_prev),
          .Overlap(w_ovl[l]), .Full(w_full[l])
        );
      end

      // Walk downwards so the lowest overlapping lane is the one left standing.
      always_comb begin
        w_hit      = 1'b0;
        w_win_cfg  = '0;
        w_win_full = 1'b0;
        w_win_idx  = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
          if (w_ovl[l]) begin
            w_hit      = 1'b1;
            w_win_cfg  = w_cfg[l];
            w_win_full = w_full[l];
            w_win_idx  = IDX_W'(int'(r_grp) * LANES + l);
          end
        end
      end

      assign w_hit_fault = ~w_win_full |
                           (~((r_priv == PRIV_M) & ~w_win_cfg[7]) & ~|(r_rwx & w_win_cfg[2:0]));
      assign w_last_adr  = w_adr[LANES-1];
    end else begin : g_none
      logic w_unused_none;
      assign w_unused_none = ^{PMPCfgFlat, PMPAdrFlat, w_hi, r_rwx};
      assign w_hit       = 1'b0;
      assign w_hit_fault = 1'b0;
      assign w_win_idx   = '0;
      assign w_last_adr  = '0;
    end
  endgenerate

  assign w_last    = (r_grp == GRP_W'(LAST_GRP));
  assign ReqReady  = (r_state == IDLE) & ~reset;
  assign RespValid = (r_state == RESP);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (ReqValid) w_next = (PMP_ENTRIES == 0) ? RESP : SCAN;
      SCAN: if (!PMPCSRWrite && (w_hit || w_last)) w_next = RESP;
      RESP: if (RespReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grp      <= '0;
      r_prev_adr <= '0;
      r_pa       <= '0;
      r_size     <= '0;
      r_rwx      <= '0;
      r_priv     <= '0;
      r_fault    <= 1'b0;
      r_matched  <= 1'b0;
      r_idx      <= '0;
    end else begin
      if (r_state == IDLE && ReqValid) begin
        r_pa       <= PhysicalAddress;
        r_size     <= Size;
        r_rwx      <= AccessRWX;
        r_priv     <= PrivilegeMode;
        r_grp      <= '0;
        r_prev_adr <= '0;
        if (PMP_ENTRIES == 0) begin
          r_fault   <= 1'b0;
          r_matched <= 1'b0;
          r_idx     <= '0;
        end
      end else if (r_state == SCAN) begin
        // A CSR write mid-scan invalidates anything seen so far, including a win this cycle.
        if (PMPCSRWrite) begin
          r_grp      <= '0;
          r_prev_adr <= '0;
        end else if (w_hit) begin
          r_matched <= 1'b1;
          r_fault   <= w_hit_fault;
          r_idx     <= w_win_idx;
        end else if (w_last) begin
          r_matched <= 1'b0;
          r_fault   <= (r_priv != PRIV_M);
          r_idx     <= '0;
        end else begin
          r_grp      <= r_grp + GRP_W'(1);
          r_prev_adr <= w_last_adr;
        end
      end
    end
  end

  assign RespFault   = r_fault;
  assign RespMatched = r_matched;
  assign RespIdx     = r_idx;
endmodule

// File: tb/tb_pmp_scan_checker.sv
// Directed and random checks of pmp_scan_checker against a region-level model.
module tb_pmp_scan_checker;
  localparam int PA = 56;
  localparam int NE = 16;
  localparam int LN = 4;
`ifdef PMP_PARTIAL_CHECK_EN
  localparam bit PART = 1'b1;
`else
  localparam bit PART = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic ReqValid = 1'b0, ReqReady;
  logic [PA-1:0] PhysicalAddress = '0;
  logic [1:0] Size = '0, PrivilegeMode = '0;
  logic [2:0] AccessRWX = '0;
  logic [8*NE-1:0] PMPCfgFlat;
  logic [(PA-2)*NE-1:0] PMPAdrFlat;
  logic PMPCSRWrite = 1'b0, RespValid, RespReady = 1'b0;
  logic RespFault, RespMatched;
  logic [3:0] RespIdx;

  logic [7:0]    cfg[NE];
  logic [PA-3:0] adr[NE];
  int n_chk = 0, n_fail = 0;

  always_comb begin
    PMPCfgFlat = '0;
    PMPAdrFlat = '0;
    for (int i = 0; i < NE; i++) begin
      PMPCfgFlat[8*i +: 8]           = cfg[i];
      PMPAdrFlat[(PA-2)*i +: (PA-2)] = adr[i];
    end
  end

  pmp_scan_checker #(.PA_BITS(PA), .PMP_ENTRIES(NE), .LANES(LN)) dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .PhysicalAddress(PhysicalAddress), .Size(Size), .AccessRWX(AccessRWX),
    .PrivilegeMode(PrivilegeMode), .PMPCfgFlat(PMPCfgFlat), .PMPAdrFlat(PMPAdrFlat),
    .PMPCSRWrite(PMPCSRWrite), .RespValid(RespValid), .RespReady(RespReady),
    .RespFault(RespFault), .RespMatched(RespMatched), .RespIdx(RespIdx)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pmp();
    for (int i = 0; i < NE; i++) begin cfg[i] = 8'h00; adr[i] = '0; end
  endtask

  // Region-level reference: first entry whose byte region touches the access wins.
  function automatic void model(input logic [63:0] pa, input logic [1:0] sz,
                                input logic [2:0] rwx, input logic [1:0] priv,
                                output bit m, output int idx, output bit f);
    logic [63:0] lo, hi, base, top, size, a;
    int k;
    lo = pa;
    hi = PART ? pa + (64'd1 << sz) - 1 : pa;
    m = 0; idx = 0; f = (priv != 2'd3);
    for (int i = 0; i < NE; i++) begin
      base = 0; top = 0;
      case (cfg[i][4:3])
        2'd1: begin base = (i == 0) ? 64'd0 : 64'(adr[i-1]) * 4; top = 64'(adr[i]) * 4; end
        2'd2: begin base = 64'(adr[i]) * 4; top = base + 4; end
        2'd3: begin
          a = 64'(adr[i]); k = 0;
          while (a[0]) begin k++; a = a >> 1; end
          size = 64'd1 << (k + 3);
          base = (64'(adr[i]) * 4) & ~(size - 1);
          top  = base + size;
        end
        default: ;
      endcase
      if (top > base && lo < top && hi >= base) begin
        m = 1; idx = i;
        if (!(lo >= base && hi < top)) f = 1;
        else if (priv == 2'd3 && !cfg[i][7]) f = 0;
        else f = ((rwx & cfg[i][2:0]) == 3'b000);
        return;
      end
    end
  endfunction

  task automatic run_req(input string tag, input logic [PA-1:0] pa, input logic [1:0] sz,
                         input logic [2:0] rwx, input logic [1:0] priv,
                         input bit em, input int eidx, input bit ef, input int elat,
                         input int csr_cyc, input int hold);
    int n;
    @(negedge clk);
    PhysicalAddress = pa; Size = sz; AccessRWX = rwx; PrivilegeMode = priv; ReqValid = 1'b1;
    chk({tag, ".ready"}, 64'(ReqReady), 64'd1);
    @(negedge clk);
    ReqValid = 1'b0;
    n = 1;
    while (RespValid !== 1'b1 && n < 40) begin
      PMPCSRWrite = (n == csr_cyc);
      @(negedge clk);
      PMPCSRWrite = 1'b0;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(elat));
    chk({tag, ".matched"}, 64'(RespMatched), 64'(em));
    chk({tag, ".fault"}, 64'(RespFault), 64'(ef));
    if (em) chk({tag, ".idx"}, 64'(RespIdx), 64'(eidx));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(RespValid), 64'd1);
      chk({tag, ".hold_fault"}, 64'(RespFault), 64'(ef));
      chk({tag, ".hold_matched"}, 64'(RespMatched), 64'(em));
    end
    RespReady = 1'b1;
    @(negedge clk);
    RespReady = 1'b0;
    chk({tag, ".released"}, 64'(RespValid), 64'd0);
  endtask

  initial begin
    bit m, f, seen;
    int idx, pv;
    logic [PA-1:0] rpa;
    logic [1:0] rsz, rpriv;
    logic [2:0] rrwx;
    clear_pmp();

    repeat (2) @(negedge clk);
    chk("reset.ready", 64'(ReqReady), 64'd0);
    chk("reset.valid", 64'(RespValid), 64'd0);
    chk("reset.fault", 64'(RespFault), 64'd0);
    chk("reset.matched", 64'(RespMatched), 64'd0);
    chk("reset.idx", 64'(RespIdx), 64'd0);
    reset = 1'b0;
    #1 chk("reset.ready_after", 64'(ReqReady), 64'd1);

    // NAPOT entry 5 at 0x800000, read-only
    cfg[5] = 8'h19; adr[5] = 54'h2001FF;
    run_req("napot_u_load", 56'h800100, 2'd3, 3'b001, 2'd0, 1, 5, 0, 3, 0, 0);
    run_req("napot_u_store", 56'h800100, 2'd3, 3'b010, 2'd0, 1, 5, 1, 3, 0, 0);
    run_req("napot_m_store", 56'h800100, 2'd3, 3'b010, 2'd3, 1, 5, 0, 3, 0, 0);
    cfg[5] = 8'h99;
    run_req("napot_m_store_l", 56'h800100, 2'd3, 3'b010, 2'd3, 1, 5, 1, 3, 0, 0);
    cfg[5] = 8'h19;
    run_req("napot_last_byte", 56'h800FFF, 2'd0, 3'b001, 2'd0, 1, 5, 0, 3, 0, 0);
    run_req("napot_past_top", 56'h801000, 2'd0, 3'b001, 2'd0, 0, 0, 1, 5, 0, 0);
    run_req("napot_straddle", 56'h800FFC, 2'd3, 3'b001, 2'd0, 1, 5, PART, 3, 0, 0);

    clear_pmp();
    cfg[0] = 8'h17; adr[0] = 54'h400;
    run_req("na4_partial", 56'h1000, 2'd3, 3'b001, 2'd0, 1, 0, PART, 2, 0, 0);

    clear_pmp();
    cfg[3] = 8'h0F; adr[3] = 54'h800;
    cfg[4] = 8'h0F; adr[4] = 54'hC00;
    run_req("tor_carry", 56'h2800, 2'd0, 3'b001, 2'd0, 1, 4, 0, 3, 0, 0);

    clear_pmp();
    run_req("off_u", 56'h1234, 2'd2, 3'b001, 2'd0, 0, 0, 1, 5, 0, 0);
    run_req("off_m", 56'h1234, 2'd2, 3'b001, 2'd3, 0, 0, 0, 5, 0, 0);

    cfg[5] = 8'h19; adr[5] = 54'h2001FF;
    run_req("csr_restart_hold", 56'h800100, 2'd3, 3'b001, 2'd0, 1, 5, 0, 5, 2, 3);

    // Reset in the second scan cycle must drop the request entirely
    clear_pmp();
    @(negedge clk);
    PhysicalAddress = 56'h40; ReqValid = 1'b1;
    @(negedge clk);
    ReqValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (RespValid === 1'b1) seen = 1; end
    chk("reset_scan.no_resp", 64'(seen), 64'd0);
    chk("reset_scan.ready", 64'(ReqReady), 64'd1);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NE; i++) begin
        cfg[i] = 8'($urandom);
        adr[i] = 54'($urandom_range(0, 'h4FF));
      end
      rpa = 56'($urandom_range(0, 'h1400));
      rsz = 2'($urandom_range(0, 3));
      rrwx = 3'b001 << $urandom_range(0, 2);
      pv = $urandom_range(0, 2);
      rpriv = (pv == 2) ? 2'd3 : 2'(pv);
      model(64'(rpa), rsz, rrwx, rpriv, m, idx, f);
      run_req($sformatf("rand%0d", t), rpa, rsz, rrwx, rpriv, m, idx, f,
              m ? idx / LN + 2 : NE / LN + 1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
